// File: rtl/weight_loader_pkg.sv
// Shared types and constants for the weight loader: FSM state encoding,
// header/checksum sizes and the header length sanity check.
package weight_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        DATA,
        CSUM
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int CSUM_WIDTH = 8;

    // A zero-length image is as unusable as one that overflows the store.
    function automatic logic len_is_bad(input logic [8*HDR_BYTES-1:0] n, input int max_words);
        return (n == '0) || (int'(n) > max_words);
    endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Byte stream in, word writes out. The master modport is the loader side,
// the slave modport is whoever feeds bytes and owns the weight memory.
interface weight_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);

    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/weight_loader_byte_packer.sv
// Packs accepted bytes little-endian into a DATA_WIDTH word and presents the
// finished word for one cycle after its last byte arrives.
module byte_packer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic                  last_byte,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_valid
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] merged;

    assign last_byte = (idx == IDX_W'(BYTES - 1));

    always_comb begin
        merged = acc;
        merged[idx*8 +: 8] = byte_in;
    end

    // The output word only changes on completion, so it stays stable for the
    // whole write cycle regardless of what the next word is doing.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            acc        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            idx        <= '0;
            acc        <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                if (last_byte) begin
                    idx        <= '0;
                    acc        <= '0;
                    word       <= merged;
                    word_valid <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                    acc <= merged;
                end
            end
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Loads a length-prefixed, checksummed weight image from a byte stream into
// the weight memory, one word write per DATA_WIDTH/8 bytes from address 0.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_WORDS  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    weight_loader_if.master       bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam int LEN_W = 8 * HDR_BYTES;

    state_t                  state;
    state_t                  next_state;
    logic                    ready;
    logic                    accept;
    logic                    start_load;
    logic                    data_accept;
    logic [7:0]              hdr_lo;
    logic [LEN_W-1:0]        hdr_len;
    logic                    hdr_bad;
    logic [LEN_W-1:0]        n_words;
    logic [LEN_W-1:0]        words_packed;
    logic                    last_word;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [CSUM_WIDTH-1:0]   csum;
    logic                    last_byte;
    logic                    word_valid;
    logic [DATA_WIDTH-1:0]   word;

    assign accept      = bus.in_valid && ready;
    assign start_load  = (state == IDLE) && start;
    assign data_accept = accept && (state == DATA);
    assign hdr_len     = {bus.in_data, hdr_lo};
    assign hdr_bad     = len_is_bad(hdr_len, NUM_WORDS);
    assign last_word   = (words_packed == n_words - 1'b1);

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_load),
        .byte_valid (data_accept),
        .byte_in    (bus.in_data),
        .last_byte  (last_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = HDR_LO;
            end
            HDR_LO: begin
                ready = 1'b1;
                if (bus.in_valid) next_state = HDR_HI;
            end
            HDR_HI: begin
                ready = 1'b1;
                if (bus.in_valid) next_state = hdr_bad ? IDLE : DATA;
            end
            DATA: begin
                ready = 1'b1;
                if (bus.in_valid && last_byte && last_word) next_state = CSUM;
            end
            CSUM: begin
                ready = 1'b1;
                if (bus.in_valid) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // words_packed counts words whose last byte has arrived (drives the exit
    // from DATA); addr and words_written follow the delayed write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_lo        <= '0;
            n_words       <= '0;
            words_packed  <= '0;
            addr          <= '0;
            csum          <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
        end else begin
            done <= 1'b0;
            if (start_load) begin
                error         <= 1'b0;
                words_written <= '0;
                csum          <= '0;
                addr          <= '0;
                words_packed  <= '0;
            end else begin
                if (accept && state == HDR_LO) begin
                    hdr_lo <= bus.in_data;
                end
                if (accept && state == HDR_HI) begin
                    n_words <= hdr_len;
                    if (hdr_bad) begin
                        done  <= 1'b1;
                        error <= 1'b1;
                    end
                end
                if (data_accept) begin
                    csum <= csum + bus.in_data;
                    if (last_byte) words_packed <= words_packed + 1'b1;
                end
                if (accept && state == CSUM) begin
                    done  <= 1'b1;
                    error <= (bus.in_data != csum);
                end
                if (word_valid) begin
                    addr          <= addr + 1'b1;
                    words_written <= words_written + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.mem_we    = word_valid;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = word;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: good/bad checksums, bad headers, stalls,
// mid-load reset and start pulses while busy, with hand-computed expectations.
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [16:0] words_written;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    logic [7:0]  stim[$];
    bit          stim_last[$];
    logic [15:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          exp_cyc[$];
    logic [31:0] exp_words [3] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};

    weight_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    weight_loader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .NUM_WORDS  (4096)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write together with the cycle it appeared in.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic buildStream(input logic [15:0] n, input int ndata, input logic [7:0] csum, input bit with_csum);
        stim.delete();
        stim_last.delete();
        stim.push_back(n[7:0]);
        stim_last.push_back(1'b0);
        stim.push_back(n[15:8]);
        stim_last.push_back(1'b0);
        for (int i = 0; i < ndata; i++) begin
            stim.push_back(8'(i + 1));
            stim_last.push_back((i % 4) == 3);
        end
        if (with_csum) begin
            stim.push_back(csum);
            stim_last.push_back(1'b0);
        end
    endtask

    // Called just after a negedge; returns at the negedge following acceptance.
    task automatic sendByte(input logic [7:0] b, input bit last_w, input bit gaps);
        int n;
        if (gaps) begin
            n = 0;
            while ($urandom_range(1, 0) == 1 && n < 8) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
                n++;
            end
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) checkOutput("ready_timeout", 64'(bus.in_ready), 64'd1);
        if (last_w) exp_cyc.push_back(cyc + 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input bit gaps, input int nbytes, input int start_at);
        for (int k = 0; k < nbytes; k++) begin
            if (k == start_at) start = 1'b1;
            sendByte(stim[k], stim_last[k], gaps);
            start = 1'b0;
        end
    endtask

    task automatic pulseStart(input string pfx);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({pfx, "_busy_after_start"}, 64'(busy), 64'd1);
        checkOutput({pfx, "_ready_after_start"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic checkReset(input string pfx);
        checkOutput({pfx, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        checkOutput({pfx, "_mem_we"}, 64'(bus.mem_we), 64'd0);
        checkOutput({pfx, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        checkOutput({pfx, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        checkOutput({pfx, "_busy"}, 64'(busy), 64'd0);
        checkOutput({pfx, "_done"}, 64'(done), 64'd0);
        checkOutput({pfx, "_error"}, 64'(error), 64'd0);
        checkOutput({pfx, "_words_written"}, 64'(words_written), 64'd0);
    endtask

    // Entered at the negedge of the cycle right after the final accepted byte.
    task automatic checkDone(input string pfx, input bit exp_err, input int exp_ww);
        checkOutput({pfx, "_done"}, 64'(done), 64'd1);
        checkOutput({pfx, "_busy_at_done"}, 64'(busy), 64'd0);
        checkOutput({pfx, "_error"}, 64'(error), 64'(exp_err));
        checkOutput({pfx, "_words_written"}, 64'(words_written), 64'(exp_ww));
        @(negedge clk);
        checkOutput({pfx, "_done_pulse"}, 64'(done), 64'd0);
        checkOutput({pfx, "_error_hold"}, 64'(error), 64'(exp_err));
    endtask

    task automatic checkWrites(input string pfx, input int n);
        checkOutput({pfx, "_write_count"}, 64'(wr_addr.size()), 64'(n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", pfx, i), 64'(wr_addr[i]), 64'(i));
            checkOutput($sformatf("%s_data%0d", pfx, i), 64'(wr_data[i]), 64'(exp_words[i]));
            if (i < exp_cyc.size())
                checkOutput($sformatf("%s_we_cycle%0d", pfx, i), 64'(wr_cyc[i]), 64'(exp_cyc[i]));
        end
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        exp_cyc.delete();
    endtask

    task automatic runGoodLoad(input string pfx, input logic [7:0] csum, input bit exp_err,
                               input bit gaps, input int start_at);
        pulseStart(pfx);
        buildStream(16'd3, 12, csum, 1'b1);
        applyStimulus(gaps, stim.size(), start_at);
        checkDone(pfx, exp_err, 3);
        repeat (2) @(negedge clk);
        checkWrites(pfx, 3);
    endtask

    task automatic runBadHeader(input string pfx, input logic [15:0] n);
        pulseStart(pfx);
        buildStream(n, 0, 8'h00, 1'b0);
        applyStimulus(1'b0, stim.size(), -1);
        checkDone(pfx, 1'b1, 0);
        repeat (3) @(negedge clk);
        checkOutput({pfx, "_no_writes"}, 64'(wr_addr.size()), 64'd0);
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        exp_cyc.delete();
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("rst");
        rst = 1'b0;
        @(negedge clk);
        checkReset("post_rst");

        // 1..12 sums to 0x4E
        runGoodLoad("good", 8'h4E, 1'b0, 1'b0, -1);
        runGoodLoad("badsum", 8'h4F, 1'b1, 1'b0, -1);
        runBadHeader("n0", 16'd0);
        runBadHeader("n4097", 16'd4097);
        runGoodLoad("stall", 8'h4E, 1'b0, 1'b1, -1);

        pulseStart("midrst");
        buildStream(16'd3, 12, 8'h4E, 1'b1);
        applyStimulus(1'b0, 8, -1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkReset("midrst_in");
        rst = 1'b0;
        @(negedge clk);
        checkReset("midrst_out");
        checkWrites("midrst", 1);
        runGoodLoad("reload", 8'h4E, 1'b0, 1'b0, -1);

        // start lands on the 6th data byte, well inside DATA
        runGoodLoad("busystart", 8'h4E, 1'b0, 1'b0, 7);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
# weight_loader

Streams a CNN weight image into the on-chip weight memory over a byte-wide valid/ready interface. It parses a 2-byte length header, packs little-endian bytes into `DATA_WIDTH` words, and issues one synchronous write per word at consecutive addresses from 0. It then checks a trailing 8-bit checksum and reports done or error. It is the write side of the weight store that the inference datapath reads one word per clock.

## Interface
- `DATA_WIDTH`, 32, word width written to memory; must be a multiple of 8.
- `ADDR_WIDTH`, 16, memory address width.
- `NUM_WORDS`, 4096, maximum accepted word count; must be ≤ 2^ADDR_WIDTH and ≤ 65535.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load; ignored while `busy`.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  write strobe, one cycle per word.
- `mem_addr`  out  ADDR_WIDTH  write address.
- `mem_wdata`  out  DATA_WIDTH  write data.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse at end of load, success or failure.
- `error`  out  1  sticky failure flag; cleared by `start` or `rst`.
- `words_written`  out  ADDR_WIDTH+1  count of words written in the current or last load.

## Operation
- A byte is accepted when `in_valid && in_ready`. `in_ready` = 1 only in HDR_LO, HDR_HI, DATA and CSUM.
- States and transitions:
  - IDLE: `start` → HDR_LO. The same edge clears `error`, `words_written`, the checksum accumulator and the byte index.
  - HDR_LO: accept byte → N[7:0]; go to HDR_HI.
  - HDR_HI: accept byte → N[15:8]. If N == 0 or N > NUM_WORDS, go to IDLE with `done`=1 and `error`=1 on the next cycle. Otherwise go to DATA.
  - DATA: byte k of the current word goes into bits [8k+7:8k], with k running 0..DATA_WIDTH/8−1 (little-endian). Each data byte is added mod 256 into the checksum. When the last byte of a word is accepted, a write is issued and the byte index wraps to 0. After word N−1's last byte, go to CSUM.
  - CSUM: accept byte. If it matches the accumulator: `done`=1, `error`=0. Otherwise: `done`=1, `error`=1. Go to IDLE.
- Header bytes and the checksum byte are excluded from the checksum.
- Write addresses run 0..N−1 with no wrap. `words_written` increments with each `mem_we`.
- `busy` = 1 in every state except IDLE.
- Reset mid-load: return to IDLE and drive all outputs to reset values. A partially packed word is discarded and never written.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0, `words_written`=0.
- `start` at edge t → `busy`=1 and `in_ready`=1 from t+1.
- Last byte of a word accepted at edge t → `mem_we`=1 during cycle t+1, with `mem_addr` and `mem_wdata` valid in that same cycle. `mem_we` is never high for two consecutive cycles when DATA_WIDTH > 8.
- Checksum byte accepted at edge t → `done` high only in cycle t+1, with `busy`=0 in that cycle. `error` is valid from t+1 and holds.
- Bad header accepted at edge t → `done`=1 and `error`=1 in cycle t+1. No `mem_we` is ever issued.
- `in_valid` may drop at any point; the loader stalls indefinitely with no timeout.
- `start` coincident with `done`: not a conflict, since the FSM is already in IDLE. It is accepted on the following cycle.
- `start` while `busy`: ignored.

## Structure
- Package `weight_loader_pkg`:
  - state enum (IDLE, HDR_LO, HDR_HI, DATA, CSUM)
  - `HDR_BYTES`=2
  - `CSUM_WIDTH`=8
- Sub-module `byte_packer`:
  - Shift/insert of bytes into a DATA_WIDTH word with byte-index counter.
  - Emits `word_valid` on completion and supports `clear`.
- Top level holds the FSM, header register, word counter, address counter and checksum.

## Test plan
- Header N=3, 12 bytes 0x01..0x0C, checksum 0x4E → writes addr0=0x04030201, addr1=0x08070605, addr2=0x0C0B0A09. Then `done`=1, `error`=0, `words_written`=3.
- Same stream with checksum 0x4F → identical three writes, then `done`=1, `error`=1.
- Header N=0, and separately N=NUM_WORDS+1 → no `mem_we`, `done`=1, `error`=1 one cycle after the HDR_HI byte.
- Case 1 with `in_valid` toggled randomly (~50%) → identical writes and results; each `mem_we` exactly one cycle after the word's final byte is accepted.
- `rst` asserted after 6 data bytes, then a fresh `start` and case 1 → only one write (addr0) before reset, all outputs at reset values, second load completes correctly from addr 0.
- `start` pulsed during DATA → no effect on state, addresses or `words_written`.
